// File: rtl/common.sv
// Shared PSG bus types: FSM state encoding and {bdir,bc1} strobe codes.
package common;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SELECT = 2'd2
    } ay_state_t;

    localparam logic [1:0] AY_STROBE_NONE = 2'b00;
    localparam logic [1:0] AY_STROBE_RD   = 2'b01;
    localparam logic [1:0] AY_STROBE_ADDR = 2'b11;
    localparam logic [1:0] AY_STROBE_DATA = 2'b10;

endpackage

// File: rtl/ay_clkdiv.sv
// Free-running 50% duty clock divider; ay_clk toggles every CLK_DIV/2 clk28 cycles.
module ay_clkdiv #(
    parameter int CLK_DIV = 16
) (
    input  logic clk28,
    input  logic rst,
    output logic ay_clk
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] div_q, div_d;
    logic          clk_q, clk_d;

    always_comb begin
        div_d = div_q + 1'b1;
        clk_d = clk_q;
        if (div_q == CW'(HALF - 1)) begin
            div_d = '0;
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            clk_q <= 1'b0;
        end else begin
            div_q <= div_d;
            clk_q <= clk_d;
        end
    end

    assign ay_clk = clk_q;

endmodule

// File: rtl/ay_multi.sv
// TurboSound-style multi-PSG bus interface: port decode, chip select intercept,
// per-chip BC1/BDIR strobes with minimum pulse stretching via cpuwait.
module ay_multi
    import common::*;
#(
    parameter int NUM_CHIPS = 2,
    parameter int CLK_DIV   = 16,
    parameter int MIN_PULSE = 3,
    localparam int SEL_W    = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic                 clk28,
    input  logic                 rst,
    input  logic                 en,
    input  logic [15:0]          a,
    input  logic [7:0]           d_in,
    input  logic                 iorq,
    input  logic                 m1,
    input  logic                 wr,
    output logic                 ay_clk,
    output logic [NUM_CHIPS-1:0] ay_bc1,
    output logic [NUM_CHIPS-1:0] ay_bdir,
    output logic [SEL_W-1:0]     sel,
    output logic                 d_out_active,
    output logic                 cpuwait
);

    localparam int         CNT_W    = $clog2(MIN_PULSE + 1);
    localparam logic [7:0] SEL_BASE = 8'(256 - NUM_CHIPS);

    logic dec_q, dec_rd, dec_addr, dec_data, dec_selw, dec_acc;
    logic [1:0] dec_code;
    logic [7:0] sel_inv;

    ay_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [1:0]            strobe_d;
    logic [NUM_CHIPS-1:0]  bc1_q, bc1_d, bdir_q, bdir_d;

    logic unused_addr;
    assign unused_addr = ^{a[13:2], a[0]};

    ay_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk28  (clk28),
        .rst    (rst),
        .ay_clk (ay_clk)
    );

    always_comb begin
        dec_q    = en & iorq & ~m1 & a[15] & ~a[1];
        dec_rd   = dec_q & a[14] & ~wr;
        dec_addr = dec_q & a[14] & wr;
        dec_data = dec_q & ~a[14] & wr;
        dec_selw = dec_addr & (d_in >= SEL_BASE);
        dec_acc  = (dec_rd | dec_addr | dec_data) & ~dec_selw;
        dec_code = AY_STROBE_NONE;
        if (dec_rd)
            dec_code = AY_STROBE_RD;
        else if (dec_addr)
            dec_code = AY_STROBE_ADDR;
        else if (dec_data)
            dec_code = AY_STROBE_DATA;
        // Chip numbering is inverted: #FF selects chip 0, #FE chip 1, ...
        sel_inv  = 8'hFF - d_in;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        strobe_d = AY_STROBE_NONE;
        case (state_q)
            IDLE: begin
                if (dec_acc) begin
                    state_d  = ACTIVE;
                    strobe_d = dec_code;
                    cnt_d    = '0;
                end else if (dec_selw) begin
                    state_d = SELECT;
                    sel_d   = sel_inv[SEL_W-1:0];
                end
            end
            ACTIVE: begin
                if (dec_acc) begin
                    strobe_d = dec_code;
                    if (cnt_q != CNT_W'(MIN_PULSE))
                        cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SELECT: begin
                // Hold here for the rest of the bus cycle so sel is written once.
                if (!iorq || !en)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_chip
        assign bc1_d[gi]  = (sel_q == SEL_W'(gi)) & strobe_d[0];
        assign bdir_d[gi] = (sel_q == SEL_W'(gi)) & strobe_d[1];
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            bc1_q   <= '0;
            bdir_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            bc1_q   <= bc1_d;
            bdir_q  <= bdir_d;
        end
    end

    assign ay_bc1       = bc1_q;
    assign ay_bdir      = bdir_q;
    assign sel          = sel_q;
    assign d_out_active = (state_q == ACTIVE) & bc1_q[sel_q] & ~bdir_q[sel_q];
    // Gated by rst so the stall drops immediately even while the decode is live.
    assign cpuwait      = ~rst & (((state_q == IDLE) & dec_acc) |
                                  ((state_q == ACTIVE) & (cnt_q < CNT_W'(MIN_PULSE - 1))));

endmodule
